// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and coordinate widths for the VGA scan generator.
// Also used by screen-object modules that consume the x/y coordinate bus.
package vga_timing_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int CNT_W = 10;
  localparam int DIV_W = 4;
  localparam int X_W   = 8;
  localparam int Y_W   = 7;

  function automatic logic in_span(input logic [CNT_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/pix_tick_div.sv
// Clock divider producing a registered one-clk strobe every CLK_DIV clocks.
// Generic enough to serve audio/tempo enables as well as the pixel clock enable.
module pix_tick_div #(
  parameter int CLK_DIV = 4,
  parameter int DIV_W   = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pix_tick
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;

  always_comb begin
    div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;
  end

  // Strobe is registered from the next count so it is high exactly while div == CLK_DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div      <= '0;
      pix_tick <= 1'b0;
    end else begin
      div      <= div_nxt;
      pix_tick <= (div_nxt == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator: pixel enable, 640x480 timing counters, downscaled x/y, syncs.
// Optional macro VGA_FRAME_TICK_EN adds a one-clk frame_start pulse at (0,0).
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int H_VIS       = vga_timing_pkg::H_VIS,
  parameter int H_FP        = vga_timing_pkg::H_FP,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BP        = vga_timing_pkg::H_BP,
  parameter int V_VIS       = vga_timing_pkg::V_VIS,
  parameter int V_FP        = vga_timing_pkg::V_FP,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BP        = vga_timing_pkg::V_BP,
  parameter int SCALE_SHIFT = 2,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  output logic           pix_tick,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           video_on,
  output logic           hsync,
  output logic           vsync
`ifdef VGA_FRAME_TICK_EN
  ,
  output logic           frame_start
`endif
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_LO = H_VIS + H_FP;
  localparam int HS_HI = HS_LO + H_SYNC - 1;
  localparam int VS_LO = V_VIS + V_FP;
  localparam int VS_HI = VS_LO + V_SYNC - 1;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);

  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             vis_nxt;
  logic             hs_act;
  logic             vs_act;

  pix_tick_div #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .pix_tick (pix_tick)
  );

  // Counters park at the last position in reset so the first tick lands on (0,0).
  always_comb begin
    h_nxt = hcount;
    v_nxt = vcount;
    if (pix_tick) begin
      if (hcount == H_LAST) begin
        h_nxt = '0;
        v_nxt = (vcount == V_LAST) ? '0 : vcount + 1'b1;
      end else begin
        h_nxt = hcount + 1'b1;
      end
    end
    vis_nxt = (h_nxt < H_VIS_C) && (v_nxt < V_VIS_C);
    hs_act  = in_span(h_nxt, HS_LO, HS_HI);
    vs_act  = in_span(v_nxt, VS_LO, VS_HI);
  end

  // Outputs decode the next counts so they stay aligned with the counters themselves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcount   <= H_LAST;
      vcount   <= V_LAST;
      video_on <= 1'b0;
      x        <= '0;
      y        <= '0;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
    end else begin
      hcount   <= h_nxt;
      vcount   <= v_nxt;
      video_on <= vis_nxt;
      x        <= vis_nxt ? X_W'(h_nxt >> SCALE_SHIFT) : '0;
      y        <= vis_nxt ? Y_W'(v_nxt >> SCALE_SHIFT) : '0;
      hsync    <= hs_act ? SYNC_POL : ~SYNC_POL;
      vsync    <= vs_act ? SYNC_POL : ~SYNC_POL;
    end
  end

`ifdef VGA_FRAME_TICK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick && (h_nxt == '0) && (v_nxt == '0);
    end
  end
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// Self-checking bench for vga_scan_gen: default 640x480 instance plus two reduced-timing instances.
// Frame-start checks are active when VGA_FRAME_TICK_EN is defined.
module tb_vga_scan_gen;

  typedef struct packed {
    logic       tick;
    logic       vo;
    logic [7:0] x;
    logic [6:0] y;
    logic       hs;
    logic       vs;
  } out_t;

  typedef struct {
    int   n;
    out_t e;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       pt, vo, hs, vs;
  logic [7:0] x;
  logic [6:0] y;
  logic       pt_s, vo_s, hs_s, vs_s;
  logic [7:0] x_s;
  logic [6:0] y_s;
  logic       pt_1, vo_1, hs_1, vs_1;
  logic [7:0] x_1;
  logic [6:0] y_1;
`ifdef VGA_FRAME_TICK_EN
  logic fs, fs_s, fs_1;
`endif

  vga_scan_gen dut (
    .clk(clk), .reset(rst_n), .pix_tick(pt), .x(x), .y(y),
    .video_on(vo), .hsync(hs), .vsync(vs)
`ifdef VGA_FRAME_TICK_EN
    , .frame_start(fs)
`endif
  );

  vga_scan_gen #(
    .CLK_DIV(2), .H_VIS(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(20), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_s (
    .clk(clk), .reset(rst_n), .pix_tick(pt_s), .x(x_s), .y(y_s),
    .video_on(vo_s), .hsync(hs_s), .vsync(vs_s)
`ifdef VGA_FRAME_TICK_EN
    , .frame_start(fs_s)
`endif
  );

  vga_scan_gen #(
    .CLK_DIV(1), .H_VIS(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(20), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_1 (
    .clk(clk), .reset(rst_n), .pix_tick(pt_1), .x(x_1), .y(y_1),
    .video_on(vo_1), .hsync(hs_1), .vsync(vs_1)
`ifdef VGA_FRAME_TICK_EN
    , .frame_start(fs_1)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  function automatic string fmt(input out_t o);
    return $sformatf("tick=%0b vo=%0b x=%0d y=%0d hs=%0b vs=%0b", o.tick, o.vo, o.x, o.y, o.hs, o.vs);
  endfunction

  function automatic out_t act_d();
    return '{pt, vo, x, y, hs, vs};
  endfunction
  function automatic out_t act_s();
    return '{pt_s, vo_s, x_s, y_s, hs_s, vs_s};
  endfunction
  function automatic out_t act_1();
    return '{pt_1, vo_1, x_1, y_1, hs_1, vs_1};
  endfunction

  // Closed-form expectation after n clock edges since reset release (active-low syncs, shift 2).
  function automatic out_t model(input int n, input int dv, input int hv, input int hfp, input int hsw,
                                 input int hbp, input int vv, input int vfp, input int vsw, input int vbp);
    int ht, vt, t, p, h, v;
    out_t o;
    o  = '{1'b0, 1'b0, 8'd0, 7'd0, 1'b1, 1'b1};
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    o.tick = (n >= 1) && ((n + 1) % dv == 0);
    t = n / dv - 1 / dv;
    if (t >= 1) begin
      p = (t - 1) % (ht * vt);
      h = p % ht;
      v = p / ht;
      o.vo = (h < hv) && (v < vv);
      if (o.vo) begin
        o.x = 8'(h >> 2);
        o.y = 7'(v >> 2);
      end
      o.hs = !((h >= hv + hfp) && (h < hv + hfp + hsw));
      o.vs = !((v >= vv + vfp) && (v < vv + vfp + vsw));
    end
    return o;
  endfunction

  function automatic out_t model_d(input int n);
    return model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction
  function automatic out_t model_s(input int n);
    return model(n, 2, 40, 4, 8, 4, 20, 2, 2, 3);
  endfunction
  function automatic out_t model_1(input int n);
    return model(n, 1, 40, 4, 8, 4, 20, 2, 2, 3);
  endfunction

  task automatic check(input string name, input int n, input out_t a, input out_t e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s n=%0d got %s want %s", name, n, fmt(a), fmt(e));
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, a, e);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  vec_t tbl[17];
  out_t rst_o;
  int   fall_c[$];
  int   fall_t[$];
  int   fs_c[$];
  int   fs_sc[$];
  int   fs_1c[$];
  int   tick_cnt, rise1, vo_cyc, vrise1;
  logic hs_prev, vs_prev;

  initial begin
    rst_o = '{1'b0, 1'b0, 8'd0, 7'd0, 1'b1, 1'b1};
    //            n      tick  vo    x       y      hs    vs
    tbl[0]  = '{0,     '{1'b0, 1'b0, 8'd0,   7'd0, 1'b1, 1'b1}};
    tbl[1]  = '{1,     '{1'b0, 1'b0, 8'd0,   7'd0, 1'b1, 1'b1}};
    tbl[2]  = '{3,     '{1'b1, 1'b0, 8'd0,   7'd0, 1'b1, 1'b1}};
    tbl[3]  = '{4,     '{1'b0, 1'b1, 8'd0,   7'd0, 1'b1, 1'b1}};
    tbl[4]  = '{7,     '{1'b1, 1'b1, 8'd0,   7'd0, 1'b1, 1'b1}};
    tbl[5]  = '{8,     '{1'b0, 1'b1, 8'd0,   7'd0, 1'b1, 1'b1}};
    tbl[6]  = '{20,    '{1'b0, 1'b1, 8'd1,   7'd0, 1'b1, 1'b1}};
    tbl[7]  = '{2560,  '{1'b0, 1'b1, 8'd159, 7'd0, 1'b1, 1'b1}};
    tbl[8]  = '{2564,  '{1'b0, 1'b0, 8'd0,   7'd0, 1'b1, 1'b1}};
    tbl[9]  = '{2624,  '{1'b0, 1'b0, 8'd0,   7'd0, 1'b1, 1'b1}};
    tbl[10] = '{2628,  '{1'b0, 1'b0, 8'd0,   7'd0, 1'b0, 1'b1}};
    tbl[11] = '{3008,  '{1'b0, 1'b0, 8'd0,   7'd0, 1'b0, 1'b1}};
    tbl[12] = '{3012,  '{1'b0, 1'b0, 8'd0,   7'd0, 1'b1, 1'b1}};
    tbl[13] = '{3200,  '{1'b0, 1'b0, 8'd0,   7'd0, 1'b1, 1'b1}};
    tbl[14] = '{3203,  '{1'b1, 1'b0, 8'd0,   7'd0, 1'b1, 1'b1}};
    tbl[15] = '{3204,  '{1'b0, 1'b1, 8'd0,   7'd0, 1'b1, 1'b1}};
    tbl[16] = '{12820, '{1'b0, 1'b1, 8'd1,   7'd1, 1'b1, 1'b1}};

    // Reset values while held in reset, then hand-computed vectors on the default instance.
    rst_n = 1'b0;
    @(negedge clk);
    check("in_reset", 0, act_d(), rst_o);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 17; i++) begin
      run_to(tbl[i].n);
      check($sformatf("tbl%0d", i), cyc, act_d(), tbl[i].e);
    end

    // Line timing on the default instance, then an asynchronous reset inside the hsync pulse.
    do_reset();
    hs_prev = 1'b1;
    tick_cnt = 0;
    rise1 = -1;
    vo_cyc = 0;
    while (cyc < 9204) begin
      step();
      check("scan_d", cyc, act_d(), model_d(cyc));
      if (pt) tick_cnt++;
      if (hs_prev && !hs) begin
        fall_c.push_back(cyc);
        fall_t.push_back(tick_cnt);
      end
      if (!hs_prev && hs && rise1 < 0) rise1 = cyc;
      if (vo && fall_c.size() == 1) vo_cyc++;
      hs_prev = hs;
    end
    check_int("hsync_falls", fall_c.size(), 3);
    if (fall_c.size() >= 3) begin
      check_int("hsync_first_fall", fall_c[0], 2628);
      check_int("line_ticks_a", fall_t[1] - fall_t[0], 800);
      check_int("line_ticks_b", fall_t[2] - fall_t[1], 800);
      check_int("hsync_low_ticks", (rise1 - fall_c[0]) / 4, 96);
    end
    check_int("video_ticks", vo_cyc / 4, 640);
    check_int("pre_rst_hs", int'(hs), 0);
    rst_n = 1'b0;
    #1;
    check("async_rst", cyc, act_d(), rst_o);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    fall_c.delete();
    hs_prev = 1'b1;
    while (cyc < 3300) begin
      step();
      check("post_rst", cyc, act_d(), model_d(cyc));
      if (hs_prev && !hs) fall_c.push_back(cyc);
      hs_prev = hs;
`ifdef VGA_FRAME_TICK_EN
      if (fs) fs_c.push_back(cyc);
`endif
    end
    check_int("post_rst_falls", fall_c.size(), 1);
    if (fall_c.size() >= 1) check_int("post_rst_fall", fall_c[0], 2628);
`ifdef VGA_FRAME_TICK_EN
    check_int("frame_start_d_cnt", fs_c.size(), 1);
    if (fs_c.size() >= 1) check_int("frame_start_d_at", fs_c[0], 4);
`endif

    // Reduced-timing instances: full frames, vsync timing, coordinate maxima, CLK_DIV=1.
    do_reset();
    fall_c.delete();
    vs_prev = 1'b1;
    vrise1 = -1;
    while (cyc < 6500) begin
      step();
      check("scan_s", cyc, act_s(), model_s(cyc));
      check("scan_1", cyc, act_1(), model_1(cyc));
      if (cyc == 2208) begin
        check_int("xmax_s", int'(x_s), 9);
        check_int("ymax_s", int'(y_s), 4);
      end
      if (vs_prev && !vs_s) fall_c.push_back(cyc);
      if (!vs_prev && vs_s && vrise1 < 0) vrise1 = cyc;
      vs_prev = vs_s;
`ifdef VGA_FRAME_TICK_EN
      if (fs_s) fs_sc.push_back(cyc);
      if (fs_1) fs_1c.push_back(cyc);
`endif
    end
    check_int("vsync_falls", fall_c.size(), 2);
    if (fall_c.size() >= 2) begin
      check_int("vsync_first_fall", fall_c[0], 2466);
      check_int("frame_lines", (fall_c[1] - fall_c[0]) / (56 * 2), 27);
      check_int("vsync_low_ticks", (vrise1 - fall_c[0]) / 2, 112);
    end
`ifdef VGA_FRAME_TICK_EN
    check_int("frame_start_s_cnt", fs_sc.size(), 3);
    foreach (fs_sc[k]) check_int("frame_start_s_at", fs_sc[k], 2 + k * 3024);
    check_int("frame_start_1_cnt", fs_1c.size(), 5);
    foreach (fs_1c[k]) check_int("frame_start_1_at", fs_1c[k], 2 + k * 1512);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
